traffic_light_nway_ctrl: RTL and testbench

//   Sensor-actuated traffic controller for N_APPROACH approaches. Each approach has a
//   car light and a pedestrian light. One approach is green at a time, served round-robin
//   by demand with min/max green, yellow and all-red clearance.

---
 rtl/traffic_light_nway_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_traffic_light_nway_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_nway_ctrl.sv
// N-approach sensor-actuated traffic controller: round-robin green service with
// min/max green, yellow, all-red clearance, pedestrian walk timing and night flash.
module traffic_light_nway_ctrl #(
    parameter int N_APPROACH = 2,
    parameter int CNT_W      = 8,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 8,
    parameter int YELLOW_T   = 2,
    parameter int ALLRED_T   = 1,
    parameter int WALK_T     = 2,
    parameter int BLINK_T    = 1,
    localparam int AW        = ($clog2(N_APPROACH) < 1) ? 1 : $clog2(N_APPROACH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_APPROACH-1:0]   S,
    input  logic [N_APPROACH-1:0]   PED_REQ,
    input  logic                    FLASH_EN,
    output logic [2*N_APPROACH-1:0] A,
    output logic [2*N_APPROACH-1:0] PA,
    output logic [AW-1:0]           ACTIVE
);

    localparam int unsigned NA = N_APPROACH;

    localparam logic [1:0] CAR_RED    = 2'b00;
    localparam logic [1:0] CAR_YELLOW = 2'b01;
    localparam logic [1:0] CAR_GREEN  = 2'b10;
    localparam logic [1:0] CAR_DARK   = 2'b11;
    localparam logic [1:0] PED_DW     = 2'b00;
    localparam logic [1:0] PED_WALK   = 2'b10;
    localparam logic [1:0] PED_FDW    = 2'b01;
    localparam logic [1:0] PED_DARK   = 2'b11;

    localparam logic [CNT_W-1:0] T_GMIN   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_BLINK  = CNT_W'(BLINK_T - 1);
    localparam logic [CNT_W-1:0] T_WALK   = CNT_W'(WALK_T);

    typedef enum logic [1:0] {
        ST_ALLRED,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        timer_q, timer_d;
    logic [AW-1:0]           active_q, active_d;
    logic [AW-1:0]           next_q, next_d;
    logic [N_APPROACH-1:0]   dem_q, dem_d;
    logic [N_APPROACH-1:0]   ped_q, ped_d;
    logic                    walk_q, walk_d;
    logic                    fpend_q, fpend_d;
    logic                    blink_q, blink_d;
    logic [2*N_APPROACH-1:0] a_q, a_d;
    logic [2*N_APPROACH-1:0] pa_q, pa_d;

    logic [N_APPROACH-1:0]   act_oh;
    logic [N_APPROACH-1:0]   clr;
    logic                    other;
    logic                    rr_found;
    logic [AW-1:0]           rr_idx;

    // First requesting approach after the active one, wrapping at N_APPROACH-1.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_idx   = active_q;
        for (int unsigned k = 1; k < NA; k++) begin
            idx = (32'(active_q) + k) % NA;
            if (!rr_found && dem_q[AW'(idx)]) begin
                rr_found = 1'b1;
                rr_idx   = AW'(idx);
            end
        end
    end

    always_comb begin
        act_oh           = '0;
        act_oh[active_q] = 1'b1;
        other            = |(dem_q & ~act_oh);
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        active_d = active_q;
        next_d   = next_q;
        walk_d   = walk_q;
        fpend_d  = fpend_q;
        blink_d  = blink_q;
        clr      = '0;

        unique case (state_q)
            ST_ALLRED: begin
                if (timer_q == T_ALLRED) begin
                    timer_d = '0;
                    if (fpend_q) begin
                        state_d = ST_FLASH;
                        blink_d = 1'b0;
                    end else begin
                        state_d      = ST_GREEN;
                        active_d     = next_q;
                        clr[next_q]  = 1'b1;
                        walk_d       = ped_q[next_q];
                    end
                end
            end
            ST_GREEN: begin
                // Max-out uses >= so demand arriving after the max still ends the green.
                if ((timer_q >= T_GMIN && (FLASH_EN || (other && !S[active_q]))) ||
                    (other && timer_q >= T_GMAX)) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                    next_d  = rr_found ? rr_idx : active_q;
                end
            end
            ST_YELLOW: begin
                if (timer_q == T_YELLOW) begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                    fpend_d = FLASH_EN;
                    walk_d  = 1'b0;
                end
            end
            ST_FLASH: begin
                if (!FLASH_EN) begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                    next_d  = '0;
                    fpend_d = 1'b0;
                    blink_d = 1'b0;
                end else if (timer_q == T_BLINK) begin
                    timer_d = '0;
                    blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = ST_ALLRED;
                timer_d = '0;
            end
        endcase

        // A clear on green entry overrides a same-cycle request.
        dem_d = (dem_q | S | PED_REQ) & ~clr;
        ped_d = (ped_q | PED_REQ) & ~clr;
    end

    // Lights are decoded from the next state so they register on the same edge.
    always_comb begin
        a_d  = '0;
        pa_d = '0;
        for (int unsigned j = 0; j < NA; j++) begin
            a_d[2*j +: 2]  = CAR_RED;
            pa_d[2*j +: 2] = PED_DW;
            unique case (state_d)
                ST_GREEN: begin
                    if (32'(active_d) == j) begin
                        a_d[2*j +: 2] = CAR_GREEN;
                        if (walk_d)
                            pa_d[2*j +: 2] = (timer_d < T_WALK) ? PED_WALK : PED_FDW;
                    end
                end
                ST_YELLOW: begin
                    if (32'(active_d) == j) begin
                        a_d[2*j +: 2] = CAR_YELLOW;
                        if (walk_d)
                            pa_d[2*j +: 2] = PED_FDW;
                    end
                end
                ST_FLASH: begin
                    a_d[2*j +: 2]  = blink_d ? CAR_DARK : CAR_YELLOW;
                    pa_d[2*j +: 2] = PED_DARK;
                end
                default: begin
                    a_d[2*j +: 2]  = CAR_RED;
                    pa_d[2*j +: 2] = PED_DW;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_ALLRED;
            timer_q  <= '0;
            active_q <= '0;
            next_q   <= '0;
            dem_q    <= '0;
            ped_q    <= '0;
            walk_q   <= 1'b0;
            fpend_q  <= 1'b0;
            blink_q  <= 1'b0;
            a_q      <= '0;
            pa_q     <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            next_q   <= next_d;
            dem_q    <= dem_d;
            ped_q    <= ped_d;
            walk_q   <= walk_d;
            fpend_q  <= fpend_d;
            blink_q  <= blink_d;
            a_q      <= a_d;
            pa_q     <= pa_d;
        end
    end

    assign A      = a_q;
    assign PA     = pa_q;
    assign ACTIVE = active_q;

endmodule

// File: tb/tb_traffic_light_nway_ctrl.sv
// Table-driven bench for traffic_light_nway_ctrl (2 approaches, default timing):
// each row holds inputs for n cycles and the light state expected after each edge.
module tb_traffic_light_nway_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] S;
    logic [1:0] PED_REQ;
    logic       FLASH_EN;
    logic [3:0] A;
    logic [3:0] PA;
    logic [0:0] ACTIVE;

    traffic_light_nway_ctrl #(
        .N_APPROACH(2),
        .CNT_W     (8),
        .GREEN_MIN (4),
        .GREEN_MAX (8),
        .YELLOW_T  (2),
        .ALLRED_T  (1),
        .WALK_T    (2),
        .BLINK_T   (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .S       (S),
        .PED_REQ (PED_REQ),
        .FLASH_EN(FLASH_EN),
        .A       (A),
        .PA      (PA),
        .ACTIVE  (ACTIVE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        bit         rst;
        logic [1:0] s;
        logic [1:0] ped;
        logic       f;
        int         n;
        logic [3:0] a;
        logic [3:0] pa;
        logic       act;
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;

    function automatic vec_t mk(input string tag, input bit rst, input logic [1:0] s,
                                input logic [1:0] ped, input logic f, input int n,
                                input logic [3:0] a, input logic [3:0] pa, input logic act);
        vec_t v;
        v.tag = tag; v.rst = rst; v.s = s; v.ped = ped; v.f = f;
        v.n = n; v.a = a; v.pa = pa; v.act = act;
        return v;
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got A=%b PA=%b ACTIVE=%b, expected A=%b PA=%b ACTIVE=%b",
                     tag, $time, got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic do_reset(input logic [1:0] s);
        S        = s;
        PED_REQ  = 2'b00;
        FLASH_EN = 1'b0;
        RST      = 1'b1;
        @(negedge CLK);
        check("reset_state", {A, PA, ACTIVE}, 9'b0);
        RST = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        logic [8:0] exp;
        for (int k = 0; k < v.n; k++) begin
            S        = v.s;
            PED_REQ  = v.ped;
            FLASH_EN = v.f;
            exp_q.push_back({v.a, v.pa, v.act});
            @(negedge CLK);
            exp = exp_q.pop_front();
            check(v.tag, {A, PA, ACTIVE}, exp);
        end
    endtask

    initial begin
        RST = 1'b1; S = 2'b00; PED_REQ = 2'b00; FLASH_EN = 1'b0;

        // idle after reset: approach 0 rests in green
        tbl.push_back(mk("idle_rest",    1, 2'b00, 2'b00, 0, 55, 4'b0010, 4'b0000, 0));
        // gap-out to approach 1
        tbl.push_back(mk("gap_green0",   1, 2'b10, 2'b00, 0, 4,  4'b0010, 4'b0000, 0));
        tbl.push_back(mk("gap_yellow0",  0, 2'b10, 2'b00, 0, 2,  4'b0001, 4'b0000, 0));
        tbl.push_back(mk("gap_allred",   0, 2'b10, 2'b00, 0, 1,  4'b0000, 4'b0000, 0));
        tbl.push_back(mk("gap_green1",   0, 2'b10, 2'b00, 0, 10, 4'b1000, 4'b0000, 1));
        // max-out alternation, period 22
        tbl.push_back(mk("max_green0",   1, 2'b11, 2'b00, 0, 8,  4'b0010, 4'b0000, 0));
        tbl.push_back(mk("max_yellow0",  0, 2'b11, 2'b00, 0, 2,  4'b0001, 4'b0000, 0));
        tbl.push_back(mk("max_allred0",  0, 2'b11, 2'b00, 0, 1,  4'b0000, 4'b0000, 0));
        tbl.push_back(mk("max_green1",   0, 2'b11, 2'b00, 0, 8,  4'b1000, 4'b0000, 1));
        tbl.push_back(mk("max_yellow1",  0, 2'b11, 2'b00, 0, 2,  4'b0100, 4'b0000, 1));
        tbl.push_back(mk("max_allred1",  0, 2'b11, 2'b00, 0, 1,  4'b0000, 4'b0000, 1));
        tbl.push_back(mk("max_green0b",  0, 2'b11, 2'b00, 0, 8,  4'b0010, 4'b0000, 0));
        tbl.push_back(mk("max_yellow0b", 0, 2'b11, 2'b00, 0, 2,  4'b0001, 4'b0000, 0));
        tbl.push_back(mk("max_allred0b", 0, 2'b11, 2'b00, 0, 1,  4'b0000, 4'b0000, 0));
        tbl.push_back(mk("max_green1b",  0, 2'b11, 2'b00, 0, 3,  4'b1000, 4'b0000, 1));
        // pedestrian call on approach 1
        tbl.push_back(mk("ped_rest0",    1, 2'b00, 2'b00, 0, 5,  4'b0010, 4'b0000, 0));
        tbl.push_back(mk("ped_pulse",    0, 2'b00, 2'b10, 0, 1,  4'b0010, 4'b0000, 0));
        tbl.push_back(mk("ped_yellow0",  0, 2'b00, 2'b00, 0, 2,  4'b0001, 4'b0000, 0));
        tbl.push_back(mk("ped_allred0",  0, 2'b00, 2'b00, 0, 1,  4'b0000, 4'b0000, 0));
        tbl.push_back(mk("ped_walk",     0, 2'b01, 2'b00, 0, 2,  4'b1000, 4'b1000, 1));
        tbl.push_back(mk("ped_fdw_grn",  0, 2'b01, 2'b00, 0, 2,  4'b1000, 4'b0100, 1));
        tbl.push_back(mk("ped_fdw_yel",  0, 2'b01, 2'b00, 0, 2,  4'b0100, 4'b0100, 1));
        tbl.push_back(mk("ped_allred1",  0, 2'b01, 2'b00, 0, 1,  4'b0000, 4'b0000, 1));
        tbl.push_back(mk("ped_green0",   0, 2'b01, 2'b00, 0, 5,  4'b0010, 4'b0000, 0));
        // night flash, demand collected during flash is served afterwards
        tbl.push_back(mk("fl_yellow",    0, 2'b01, 2'b00, 1, 2,  4'b0001, 4'b0000, 0));
        tbl.push_back(mk("fl_allred",    0, 2'b01, 2'b00, 1, 1,  4'b0000, 4'b0000, 0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk((i % 2 == 0) ? "fl_on" : "fl_off", 0, 2'b10, 2'b00, 1, 1,
                             (i % 2 == 0) ? 4'b0101 : 4'b1111, 4'b1111, 0));
        tbl.push_back(mk("fl_exit_ar",   0, 2'b00, 2'b00, 0, 1,  4'b0000, 4'b0000, 0));
        tbl.push_back(mk("fl_green0",    0, 2'b00, 2'b00, 0, 4,  4'b0010, 4'b0000, 0));
        tbl.push_back(mk("fl_yellow0",   0, 2'b00, 2'b00, 0, 2,  4'b0001, 4'b0000, 0));
        tbl.push_back(mk("fl_allred0",   0, 2'b00, 2'b00, 0, 1,  4'b0000, 4'b0000, 0));
        tbl.push_back(mk("fl_green1",    0, 2'b00, 2'b00, 0, 3,  4'b1000, 4'b0000, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst)
                do_reset(tbl[i].s);
            run_row(tbl[i]);
        end

        // asynchronous reset in the middle of a yellow phase
        do_reset(2'b10);
        run_row(mk("ar_green0",  0, 2'b10, 2'b00, 0, 4, 4'b0010, 4'b0000, 0));
        run_row(mk("ar_yellow0", 0, 2'b10, 2'b00, 0, 1, 4'b0001, 4'b0000, 0));
        #2 RST = 1'b1;
        #1 check("async_reset", {A, PA, ACTIVE}, 9'b0);
        @(negedge CLK);
        check("async_reset_hold", {A, PA, ACTIVE}, 9'b0);
        RST = 1'b0;
        run_row(mk("ar_after", 0, 2'b00, 2'b00, 0, 12, 4'b0010, 4'b0000, 0));

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
